// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, taken-branch and slow data-memory hazards.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
  // Control word order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] RUN_O = 7'b1101011;
  localparam logic [6:0] FRZ_O = 7'b0000000;
  localparam logic [6:0] BR_O  = 7'b1111111;
  localparam logic [6:0] LU_O  = 7'b0001111;
  localparam logic [6:0] RST_O = 7'b0010100;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic [6:0] o;
  logic lu, ms, hold, fl_ev;
  assign lu = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign ms = mem_req & ~mem_ready;
  // Once waiting on memory, only mem_ready releases, even if the request drops.
  assign hold = (state_q == MEM_WAIT) ? ~mem_ready : ms;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    o = RUN_O;
    fl_ev = 1'b0;
    if (state_q == LOAD_STALL) begin
      o = ms ? FRZ_O : LU_O;
      if (!ms) begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q <= 4'd1) ? RUN : LOAD_STALL;
      end
    end else if (hold) begin
      o = FRZ_O;
      state_d = MEM_WAIT;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        o = BR_O;
        fl_ev = 1'b1;
      end else if (lu) begin
        o = LU_O;
        if (LOAD_STALL_CYCLES > 1) begin
          cnt_d = 4'(LOAD_STALL_CYCLES - 1);
          state_d = LOAD_STALL;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_q <= (~o[6] & ~&stall_q) ? stall_q + 1'b1 : stall_q;
      flush_q <= (fl_ev & ~&flush_q) ? flush_q + 1'b1 : flush_q;
    end
  end
  assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = reset ? RST_O : o;
  assign busy = ~reset & (state_q != RUN);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench driving one-cycle and three-cycle load-stall variants side by side.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  wire [7:0] v1, v3;
  wire [15:0] sc1, fc1, sc3, fc3;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] e1, e3;
    logic [15:0] s1, f1, s3, f3;
  } exp_t;
  exp_t q[$];
  logic [15:0] s1 = '0, f1 = '0, s3 = '0, f3 = '0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(v1[7]), .if_id_en(v1[6]), .if_id_flush(v1[5]), .id_ex_en(v1[4]), .id_ex_flush(v1[3]),
    .ex_mem_en(v1[2]), .mem_wb_en(v1[1]), .stall_cnt(sc1), .flush_cnt(fc1), .busy(v1[0]));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(v3[7]), .if_id_en(v3[6]), .if_id_flush(v3[5]), .id_ex_en(v3[4]), .id_ex_flush(v3[3]),
    .ex_mem_en(v3[2]), .mem_wb_en(v3[1]), .stall_cnt(sc3), .flush_cnt(fc3), .busy(v3[0]));
  // Expected vectors {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_en,busy}
  localparam logic [7:0] RST = 8'h28, NRM = 8'hD6, FRZ = 8'h00, WAIT = 8'h01, REL = 8'hD7;
  localparam logic [7:0] BR = 8'hFE, BRREL = 8'hFF, LU = 8'h1E, LS = 8'h1F;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] ert, input logic br, input logic mq,
                      input logic mrdy, input logic [7:0] e1, input logic [7:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
    ex_branch_taken = br; mem_req = mq; mem_ready = mrdy;
    if (r) begin
      s1 = '0; f1 = '0; s3 = '0; f3 = '0;
    end
    e.e1 = e1; e.e3 = e3; e.s1 = s1; e.f1 = f1; e.s3 = s3; e.f3 = f3;
    q.push_back(e);
    if (!r) begin
      s1 = sat_inc(s1, ~e1[7]); f1 = sat_inc(f1, e1[5]);
      s3 = sat_inc(s3, ~e3[7]); f3 = sat_inc(f3, e3[5]);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (v1 !== e.e1) begin
        failures++;
        $display("FAIL ctl_lsc1 t=%0t got=%h exp=%h", $time, v1, e.e1);
      end
      if (v3 !== e.e3) begin
        failures++;
        $display("FAIL ctl_lsc3 t=%0t got=%h exp=%h", $time, v3, e.e3);
      end
      if (sc1 !== e.s1 || fc1 !== e.f1) begin
        failures++;
        $display("FAIL cnt_lsc1 t=%0t stall=%h/%h flush=%h/%h", $time, sc1, e.s1, fc1, e.f1);
      end
      if (sc3 !== e.s3 || fc3 !== e.f3) begin
        failures++;
        $display("FAIL cnt_lsc3 t=%0t stall=%h/%h flush=%h/%h", $time, sc3, e.s3, fc3, e.f3);
      end
    end
  end
  initial begin
    // reset then idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // load-use on rs
    step(0, 8, 0, 0, 1, 8, 0, 0, 0, LU, LU);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // load into r0 never stalls; rt match without id_uses_rt never stalls
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, NRM);
    step(0, 0, 5, 0, 1, 5, 0, 0, 0, NRM, NRM);
    // load-use on rt
    step(0, 0, 5, 1, 1, 5, 0, 0, 0, LU, LU);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // memory stall arriving during a load stall freezes and holds the stall count
    step(0, 8, 0, 0, 1, 8, 0, 0, 0, LU, LU);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, WAIT);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, REL, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, LS);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // four-cycle memory wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, WAIT);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, REL, REL);
    // branch held through a memory wait flushes only on release
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, FRZ);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0, WAIT, WAIT);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, BRREL, BRREL);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // branch wins over a simultaneous load-use
    step(0, 8, 0, 0, 1, 8, 1, 0, 0, BR, BR);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // reset mid memory wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, WAIT);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, RST, RST);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    // drive the stall counter into saturation
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, WAIT);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, REL, REL);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, REL, REL);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: load-use hazards (ID vs EX), taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It also keeps saturating stall and flush counters for performance debug.

Parameters:
LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  destination register of the load in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
mem_req  in  1  MEM stage issues a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
flush_cnt  out  CNT_W  saturating count of branch flush events
busy  out  1  state != RUN

Behaviour:
- Reset is asynchronous and active-high. While reset=1: state=RUN, stall counter=0, stall_cnt=0, flush_cnt=0. All *_en=0, if_id_flush=1, id_ex_flush=1, busy=0.
- States RUN, LOAD_STALL, MEM_WAIT are registered. Outputs are combinational (Mealy) from state and the current inputs.
- Load-use hazard: lu = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Memory stall: ms = mem_req & ~mem_ready.
- Priority within RUN: ms > ex_branch_taken > lu > normal.
- RUN, normal: all *_en=1, flushes=0.
- RUN, ms=1: all five enables=0, flushes=0, next state MEM_WAIT. A pending branch or hazard is held in place and re-evaluated after release.
- MEM_WAIT: all enables=0, flushes=0. When mem_ready=1, enables=1 in that same cycle and next state=RUN.
- RUN, ex_branch_taken=1 (ms=0): pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. flush_cnt increments. State stays RUN. A simultaneous lu is ignored because the ID instruction is squashed.
- RUN, lu=1 (no ms, no branch): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - If LOAD_STALL_CYCLES>1: stall counter is loaded with LOAD_STALL_CYCLES-1 and next state is LOAD_STALL. Otherwise stay in RUN; the load has moved to MEM next cycle, so lu clears.
- LOAD_STALL: same outputs as the lu case; the counter decrements each cycle. When the counter reaches 0, next state is RUN.
  - If ms=1 in LOAD_STALL: freeze all enables and hold the counter. The state stays LOAD_STALL until mem_ready=1.
- Flush takes priority over enable on the same register.
- Counters saturate at all-ones and never wrap. stall_cnt increments on every cycle with reset=0 and pc_en=0.
- Reset asserted mid-MEM_WAIT or mid-LOAD_STALL aborts immediately to the reset outputs. No pending stall survives reset.

Test Plan:
1. Reset 2 cycles, then no hazards -> all enables=1, flushes=0, busy=0, stall_cnt=0, flush_cnt=0.
2. ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle (LOAD_STALL_CYCLES=1) -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle, stall_cnt=1. Repeat with ex_rt=0 -> no stall.
3. LOAD_STALL_CYCLES=3, id_uses_rt=1, id_rt=ex_rt=5 -> 3 consecutive stall cycles, busy=1 for 2 cycles, stall_cnt=3.
4. mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all enables=0 for 4 cycles, all=1 on the 5th, stall_cnt=4. ex_branch_taken held during the wait -> flush fires only on the release cycle, flush_cnt=1.
5. ex_branch_taken=1 together with lu=1 -> flush outputs only, pc_en=1, no stall, flush_cnt+1, stall_cnt unchanged.
6. Assert reset during MEM_WAIT -> outputs go to reset values immediately. After deassert, state=RUN and counters=0. Preload stall_cnt near saturation -> holds at 0xFFFF.
